// File: rtl/acumulador_suma_if.sv
// Handshake bundle for acumulador_suma: batch start, operand transfer and the result/status outputs.
interface acumulador_suma_if #(
  parameter int M = 4
);
  logic         start;
  logic         in_valid;
  logic [M-1:0] B;
  logic         in_ready;
  logic [M-1:0] R;
  logic         C;
  logic         busy;
  logic         done;

  modport master (
    output start, in_valid, B,
    input  in_ready, R, C, busy, done
  );

  modport slave (
    input  start, in_valid, B,
    output in_ready, R, C, busy, done
  );
endinterface

// File: rtl/acumulador_suma.sv
// Batch accumulator: sums N operands into an M-bit register with a sticky carry-out flag.
// Optional macro ACUMULADOR_SATURATE_EN clamps the accumulator to all ones on carry-out instead of wrapping.
module acumulador_suma #(
  parameter int M = 4,
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_n,
  acumulador_suma_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [M-1:0]  acc_q;
  logic          carry_q;
  logic [CW-1:0] count_q;

  logic [M:0]    sum_d;
  logic [M-1:0]  acc_d;

  function automatic logic [M-1:0] next_acc(input logic [M:0] s);
`ifdef ACUMULADOR_SATURATE_EN
    // Once any addition overflows the result stays pinned at full scale.
    return s[M] ? {M{1'b1}} : s[M-1:0];
`else
    return s[M-1:0];
`endif
  endfunction

  // Ripple-carry adder feeding the register back as one operand
  assign sum_d = {1'b0, acc_q} + {1'b0, bus.B};
  assign acc_d = next_acc(sum_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= ACUM;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
          end
        end
        ACUM: begin
          if (bus.in_valid) begin
            acc_q   <= acc_d;
            carry_q <= carry_q | sum_d[M];
            count_q <= count_q + CW'(1);
            if (count_q == LAST) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_q == ACUM);
  assign bus.busy     = (state_q == ACUM);
  assign bus.done     = (state_q == DONE);
  assign bus.R        = acc_q;
  assign bus.C        = carry_q;

endmodule

// File: tb/tb_acumulador_suma.sv
// Bench for acumulador_suma: three instances (N=4,3,1, M=4) checked every cycle against a running-total model.
module tb_acumulador_suma;

  localparam int M   = 4;
  localparam int NI  = 3;
  localparam int MOD = 1 << M;

  logic clk;
  logic rst_n;

  logic         start_a    [NI];
  logic         vld_a      [NI];
  logic [M-1:0] b_a        [NI];
  logic         rdy_a      [NI];
  logic [M-1:0] r_a        [NI];
  logic         c_a        [NI];
  logic         busy_a     [NI];
  logic         done_a     [NI];

  int checks;
  int errors;

  // Model: 0 idle, 1 accumulating, 2 done; total is the exact integer sum of accepted operands.
  int phase [NI];
  int total [NI];
  int cnt   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    acumulador_suma_if #(.M(M)) bus ();
    assign bus.start    = start_a[g];
    assign bus.in_valid = vld_a[g];
    assign bus.B        = b_a[g];
    assign rdy_a[g]     = bus.in_ready;
    assign r_a[g]       = bus.R;
    assign c_a[g]       = bus.C;
    assign busy_a[g]    = bus.busy;
    assign done_a[g]    = bus.done;
    acumulador_suma #(.M(M), .N(g == 0 ? 4 : (g == 1 ? 3 : 1))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  function automatic int nval(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic int exp_r(input int k);
`ifdef ACUMULADOR_SATURATE_EN
    return (total[k] >= MOD) ? MOD - 1 : total[k];
`else
    return total[k] % MOD;
`endif
  endfunction

  function automatic bit exp_c(input int k);
    return total[k] >= MOD;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        phase[k] = 0; total[k] = 0; cnt[k] = 0;
      end else if (phase[k] == 1) begin
        if (vld_a[k]) begin
          total[k] = total[k] + int'(b_a[k]);
          cnt[k]   = cnt[k] + 1;
          if (cnt[k] == nval(k)) phase[k] = 2;
        end
      end else if (start_a[k]) begin
        phase[k] = 1; total[k] = 0; cnt[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (int'(r_a[k]) != exp_r(k) || c_a[k] != exp_c(k) || rdy_a[k] != (phase[k] == 1) ||
          busy_a[k] != (phase[k] == 1) || done_a[k] != (phase[k] == 2)) begin
        errors++;
        $display("FAIL model inst%0d t=%0t: R=%0d C=%0b rdy=%0b busy=%0b done=%0b, expected R=%0d C=%0b rdy=%0b busy=%0b done=%0b",
                 k, $time, r_a[k], c_a[k], rdy_a[k], busy_a[k], done_a[k],
                 exp_r(k), exp_c(k), phase[k] == 1, phase[k] == 1, phase[k] == 2);
      end
    end
  end

  task automatic pin(input string nm, input int k, input int er, input bit ec,
                     input bit ebusy, input bit edone);
    checks++;
    if (int'(r_a[k]) != er || c_a[k] != ec || busy_a[k] != ebusy || rdy_a[k] != ebusy || done_a[k] != edone) begin
      errors++;
      $display("FAIL %s inst%0d: R=%0d C=%0b busy=%0b rdy=%0b done=%0b, expected R=%0d C=%0b busy=%0b done=%0b",
               nm, k, r_a[k], c_a[k], busy_a[k], rdy_a[k], done_a[k], er, ec, ebusy, edone);
    end
  endtask

  // All drive tasks begin and end just after a falling edge.
  task automatic pulse_start(input int k);
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [M-1:0] b, input int gap);
    vld_a[k] = 1'b1;
    b_a[k]   = b;
    @(negedge clk);
    vld_a[k] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int k, input int budget);
    int n;
    n = 0;
    while (!done_a[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done_a[k]) begin
      errors++;
      $display("FAIL %s inst%0d: done=0 after %0d cycles, expected done=1", nm, k, budget);
    end
  endtask

  int ovf_r;
  int ign_r;

  initial begin
`ifdef ACUMULADOR_SATURATE_EN
    ovf_r = 15; ign_r = 15;
`else
    ovf_r = 2;  ign_r = 10;
`endif
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start_a[k] = 1'b0; vld_a[k] = 1'b0; b_a[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) pin("reset_state", k, 0, 1'b0, 1'b0, 1'b0);

    // Basic batch 1+2+3+4
    pulse_start(0);
    pin("start_to_acum", 0, 0, 1'b0, 1'b1, 1'b0);
    send(0, 4'd1, 0); send(0, 4'd2, 0); send(0, 4'd3, 0);
    pin("no_early_done", 0, 6, 1'b0, 1'b1, 1'b0);
    send(0, 4'd4, 0);
    pin("basic_batch", 0, 10, 1'b0, 1'b0, 1'b1);

    // Same operands with two idle cycles between transfers
    pulse_start(0);
    send(0, 4'd1, 2); send(0, 4'd2, 2); send(0, 4'd3, 2);
    pin("gap_no_early_done", 0, 6, 1'b0, 1'b1, 1'b0);
    send(0, 4'd4, 2);
    wait_done("gap_done", 0, 10);
    pin("gap_batch", 0, 10, 1'b0, 1'b0, 1'b1);

    // Start during ACUM is ignored; 5+6+7+8 = 26 overflows
    pulse_start(0);
    send(0, 4'd5, 0);
    pulse_start(0);
    pin("start_ignored", 0, 5, 1'b0, 1'b1, 1'b0);
    send(0, 4'd6, 0); send(0, 4'd7, 0); send(0, 4'd8, 0);
    pin("ignored_start_sum", 0, ign_r, 1'b1, 1'b0, 1'b1);
    vld_a[0] = 1'b1; b_a[0] = 4'd7;
    repeat (2) @(negedge clk);
    vld_a[0] = 1'b0;
    pin("done_ignores_valid", 0, ign_r, 1'b1, 1'b0, 1'b1);
    start_a[0] = 1'b1; vld_a[0] = 1'b1; b_a[0] = 4'd7;
    @(negedge clk);
    start_a[0] = 1'b0; vld_a[0] = 1'b0;
    pin("start_with_valid", 0, 0, 1'b0, 1'b1, 1'b0);
    send(0, 4'd0, 0);
    pin("zero_counts", 0, 0, 1'b0, 1'b1, 1'b0);

    // Overflow on N=3
    pulse_start(1);
    send(1, 4'd15, 0); send(1, 4'd1, 0); send(1, 4'd2, 0);
    pin("overflow", 1, ovf_r, 1'b1, 1'b0, 1'b1);

    // N=1 and restart from DONE
    pulse_start(2);
    send(2, 4'd9, 0);
    pin("n1_batch", 2, 9, 1'b0, 1'b0, 1'b1);
    pulse_start(2);
    pin("restart_from_done", 2, 0, 1'b0, 1'b1, 1'b0);
    send(2, 4'd6, 0);
    pin("n1_second", 2, 6, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-batch
    pulse_start(0);
    send(0, 4'd3, 0); send(0, 4'd5, 0);
    pin("pre_reset", 0, 8, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 pin("async_reset", 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    send(0, 4'd2, 0);
    pin("clean_after_reset", 0, 2, 1'b0, 1'b1, 1'b0);

    // Randomized traffic on all instances
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NI; k++) begin
        start_a[k] = ($urandom_range(0, 7) == 0);
        vld_a[k]   = ($urandom_range(0, 1) == 1);
        b_a[k]     = M'($urandom);
      end
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++) begin
      start_a[k] = 1'b0; vld_a[k] = 1'b0;
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acumulador_suma.md
Name: acumulador_suma

Overview:
- Sequential accumulator stage that consumes the M-bit ripple-carry sum and feeds it back as one operand.
- Adds a batch of N operands, presented one per handshake, into an M-bit register.
- Reports the total on R, a sticky carry flag C, and a done indication to downstream logic (display or ALU result register).
- Internal adder is an M-bit ripple-carry sum: acc + B, with carry-out of bit M-1.

Parameters:
- M, 4, operand/accumulator width in bits (M >= 2).
- N, 4, operands per batch (N >= 1); counter width is $clog2(N+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a new batch.
- in_valid  input  1  operand B valid this cycle.
- B  input  M  operand to add.
- in_ready  output  1  block accepts B this cycle.
- R  output  M  accumulator value, registered.
- C  output  1  sticky carry: 1 if any addition in the batch carried out of bit M-1.
- busy  output  1  high in ACUM.
- done  output  1  high in DONE; batch result valid on R/C.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, R=0, C=0, count=0, in_ready=0, busy=0, done=0. Takes effect immediately, including mid-batch; the partial batch is discarded.
- States: IDLE, ACUM, DONE. All outputs are decoded from registers; there is no combinational path from input to output.
  - in_ready = busy = (state==ACUM); done = (state==DONE).
- IDLE:
  - start=1 -> next cycle: R=0, C=0, count=0, state=ACUM.
  - in_valid is ignored.
- ACUM:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - On transfer: {cy, sum} = R + B (M+1 bits); R <= sum (mod 2^M); C <= C | cy; count <= count+1.
  - The transfer that makes count reach N moves the state to DONE in the same edge. R/C hold the final value the cycle done first rises. Latency from the last transfer to done=1 is 1 clock.
  - No transfer: R, C, count hold.
  - start in ACUM is ignored; the batch is never restarted mid-operation except by reset.
- DONE:
  - R and C hold. done=1 for as long as the state is DONE.
  - start=1 -> clear R/C/count and go to ACUM (same as from IDLE).
  - in_valid is ignored (in_ready=0).
- Boundary cases:
  - N=1: a single transfer goes to DONE.
  - B=0 transfers still count.
  - Wrap: R=2^M-1 plus B=1 gives R=0, C=1.
  - start and in_valid together in IDLE/DONE: only start acts; B is not accumulated.

Optional Feature:
- Macro: ACUMULADOR_SATURATE_EN.
- Defined: on a transfer with cy=1, R <= 2^M-1 (all ones) instead of the wrapped sum. C is still set sticky. Once saturated, R stays at 2^M-1 for the rest of the batch.
- Undefined: modulo-2^M wrap as described above. This is the default build.

Test Plan:
- Reset mid-batch: M=4,N=4; start, transfer B=3, B=5, then pull rst_n low between edges -> R=0, C=0, state IDLE, in_ready=0 asynchronously. The next start begins a clean batch.
- Basic batch: M=4,N=4; start; B=1,2,3,4 on consecutive cycles with in_valid=1 -> done=1 one cycle after the 4th transfer, R=10, C=0, busy=0.
- Backpressure/gaps: the same operands with in_valid low for 2 cycles between each -> identical result R=10. Count advances only on transfers; done does not rise early.
- Overflow wrap: M=4,N=3; B=15,1,2 -> R=2, C=1. With ACUMULADOR_SATURATE_EN: R=15, C=1.
- Ignored inputs: start pulse during ACUM after 1 transfer -> no clear; batch completes with the correct sum. in_valid=1 with B=7 in DONE -> R unchanged.
- Restart from DONE and N=1: N=1; start, B=9 -> R=9, done. Then start -> R=0, C=0, busy=1 next cycle, and B=6 -> R=6, done.
